sha256_core_ctrl: RTL and testbench

Sequencer for one SHA-256 compression of a 512-bit message block. It owns the 256-bit working state {A..H}, the chaining hash H0..H7, a 16-word message-schedule window and the 64-entry K constant ROM. It steps the combinational `Hash_Round` datapath once per cycle for 64 rounds, then folds the result into the chaining hash. It sits between the padding/block-feed logic upstream and the digest consumer downstream.

---
 rtl/sha256_core_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sha256_core_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_core_ctrl.sv
// sha256_core_ctrl: sequences one SHA-256 compression of a 512-bit block.
// Owns the working state {A..H}, the chaining hash H0..H7, a 16-word
// message-schedule window and the K constant ROM. One round per cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a block; start loads window and working state
// ROUND | round t (0..63) applied each cycle; window slides by one word
// FINAL | done pulse; digest already holds the folded result
module sha256_core_ctrl #(
  parameter int BIT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 init,
  input  logic [16*BIT_W-1:0]  block,
  output logic                 ready,
  output logic                 done,
  output logic [8*BIT_W-1:0]   digest
);

  generate
    if (BIT_W != 32) begin : g_bad_width
      $error("sha256_core_ctrl: only BIT_W = 32 is supported");
    end
  endgenerate

  typedef logic [BIT_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (BIT_W - n));
  endfunction

  function automatic word_t big_sig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t     state;
  state_t     state_nxt;
  logic [5:0] t;
  logic       accept;
  logic       last_round;

  word_t hash [8];
  word_t work [8];
  word_t win  [16];

  word_t round_out [8];
  word_t win_new;
  word_t k_t;
  word_t temp1;
  word_t temp2;
  word_t ch;
  word_t maj;

  // State register; reset always returns to IDLE, discarding any run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the handshake outputs and datapath strobes.
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_round = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (t == 6'd63) begin
          last_round = 1'b1;
          state_nxt  = FINAL;
        end
      end
      FINAL: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One compression round and the next schedule word, both from current regs.
  always_comb begin
    k_t   = K_ROM[t];
    ch    = (work[4] & work[5]) ^ (~work[4] & work[6]);
    maj   = (work[0] & work[1]) ^ (work[0] & work[2]) ^ (work[1] & work[2]);
    temp1 = work[7] + big_sig1(work[4]) + ch + k_t + win[0];
    temp2 = big_sig0(work[0]) + maj;
    round_out[0] = temp1 + temp2;
    round_out[1] = work[0];
    round_out[2] = work[1];
    round_out[3] = work[2];
    round_out[4] = work[3] + temp1;
    round_out[5] = work[4];
    round_out[6] = work[5];
    round_out[7] = work[6];
    win_new = small_sig1(win[14]) + win[9] + small_sig0(win[1]) + win[0];
  end

  // Datapath registers. The fold into the chaining hash happens on the edge
  // that retires round 63, so digest is already final while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      t <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        hash[i] <= IV[i];
        work[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      t <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= block[16*BIT_W-1-BIT_W*i -: BIT_W];
      end
      for (int i = 0; i < 8; i++) begin
        if (init) begin
          hash[i] <= IV[i];
          work[i] <= IV[i];
        end else begin
          work[i] <= hash[i];
        end
      end
    end else if (state == ROUND) begin
      t <= t + 6'd1;
      for (int i = 0; i < 8; i++) begin
        work[i] <= round_out[i];
        if (last_round) begin
          hash[i] <= hash[i] + round_out[i];
        end
      end
      for (int i = 0; i < 15; i++) begin
        win[i] <= win[i+1];
      end
      win[15] <= win_new;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digest
      assign digest[8*BIT_W-1-BIT_W*gi -: BIT_W] = hash[gi];
    end
  endgenerate

endmodule

// File: tb/tb_sha256_core_ctrl.sv
// Bench for sha256_core_ctrl: known digests plus a plain-arithmetic SHA-256
// reference model for random blocks and chaining.
module tb_sha256_core_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         init;
  logic [511:0] block;
  logic         ready;
  logic         done;
  logic [255:0] digest;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] IV_DG =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_core_ctrl #(.BIT_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .init   (init),
    .block  (block),
    .ready  (ready),
    .done   (done),
    .digest (digest)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-word schedule, then 64 rounds.
  function automatic logic [255:0] sha_comp(input logic [255:0] h_in, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) begin
      h[i] = h_in[255-32*i -: 32];
      v[i] = h[i];
    end
    for (int r = 0; r < 64; r++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r] + w[r];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[511-32*j -: 32] = $urandom;
    return b;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run_block(input logic [511:0] blk, input logic ini, input string tag,
                           input logic [255:0] exp, input bit disturb);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/ready_idle"}, 256'(ready), 256'(1'b1));
    block = blk;
    init  = ini;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    block = rand_block();
    init  = ~ini;
    check({tag, "/ready_busy"}, 256'(ready), 256'(1'b0));
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      if (disturb) begin
        block = rand_block();
        start = (n < 60) && (n % 7 == 3);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "/latency"}, 256'(n), 256'(65));
    check({tag, "/digest"}, digest, exp);
    check({tag, "/ready_final"}, 256'(ready), 256'(1'b0));
    @(negedge clk);
    check({tag, "/done_single"}, 256'(done), 256'(1'b0));
    check({tag, "/ready_after"}, 256'(ready), 256'(1'b1));
    check({tag, "/digest_hold"}, digest, exp);
  endtask

  logic [511:0] abc_blk;
  logic [511:0] empty_blk;
  logic [447:0] msg56;
  logic [511:0] blk1, blk2, rblk;
  logic [255:0] h_ref;
  logic         ini;
  bit           saw_done;

  initial begin
    abc_blk   = {24'h616263, 8'h80, 416'h0, 64'd24};
    empty_blk = {8'h80, 440'h0, 64'd0};
    msg56     = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    blk1      = {msg56, 8'h80, 56'h0};
    blk2      = {448'h0, 64'd448};

    reset = 1'b1;
    start = 1'b0;
    init  = 1'b0;
    block = '0;
    repeat (3) @(negedge clk);
    check("rst/ready", 256'(ready), 256'(1'b1));
    check("rst/done", 256'(done), 256'(1'b0));
    check("rst/digest", digest, IV_DG);
    reset = 1'b0;
    @(negedge clk);

    run_block(abc_blk, 1'b1, "abc", ABC_DG, 1'b0);
    run_block(empty_blk, 1'b1, "empty", EMPTY_DG, 1'b0);

    // Interrupted run chaining from the empty digest: reset must restore IV.
    block = abc_blk;
    init  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid/ready", 256'(ready), 256'(1'b1));
    check("rstmid/done", 256'(done), 256'(1'b0));
    check("rstmid/digest", digest, IV_DG);
    saw_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("rstmid/no_done", 256'(saw_done), 256'(1'b0));

    // Reset and start on the same edge: no accept.
    block = abc_blk;
    init  = 1'b1;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rststart/ready", 256'(ready), 256'(1'b1));
    @(negedge clk);
    check("rststart/still_idle", 256'(ready), 256'(1'b1));

    run_block(abc_blk, 1'b1, "abc_again", ABC_DG, 1'b0);

    run_block(blk1, 1'b1, "two_b1", sha_comp(IV_DG, blk1), 1'b0);
    run_block(blk2, 1'b0, "two_b2", TWO_DG, 1'b0);

    run_block(abc_blk, 1'b1, "abc_disturb", ABC_DG, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ini  = (i == 0) || ($urandom_range(0, 2) == 0);
      rblk = rand_block();
      if (ini) h_ref = IV_DG;
      h_ref = sha_comp(h_ref, rblk);
      run_block(rblk, ini, $sformatf("rand%0d", i), h_ref, (i % 2) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
